// File: rtl/btn_pkg.sv
`default_nettype none
// ==========================================================================
// btn_pkg : FSM state type and default timing for btn_press_classifier
// Rev 1.0
// ==========================================================================
package btn_pkg;

   typedef enum logic [1:0] {
      LOCKOUT = 2'd0,
      IDLE    = 2'd1,
      HELD    = 2'd2,
      LONG    = 2'd3
   } btn_state_e;

   localparam int DEBOUNCE_CYC_DEF = 1_000_000;
   localparam int LONG_CYC_DEF     = 50_000_000;
   localparam int REPEAT_CYC_DEF   = 10_000_000;
   localparam int CNT_W_DEF        = 26;

endpackage
`default_nettype wire

// File: rtl/btn_sync_debounce.sv
`default_nettype none
// ==========================================================================
// btn_sync_debounce : pad synchroniser, polarity normalisation, debouncer
// Rev 1.0
// ==========================================================================
module btn_sync_debounce
   import btn_pkg::*;
#(
   parameter int BTN_ACTIVE_LOW = 1,
   parameter int DEBOUNCE_CYC   = DEBOUNCE_CYC_DEF,
   parameter int CNT_W          = CNT_W_DEF
) (
   input  logic clk_50MHz,
   input  logic rst_n,
   input  logic btn_raw_i,
   output logic btn_db_o,
   output logic btn_pend_o
);

   localparam logic             c_REL_LVL = (BTN_ACTIVE_LOW != 0);
   localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [1:0]       sync_q;
   logic             db_q, db_d;
   logic [CNT_W-1:0] stab_q, stab_d;
   logic             w_lvl;

   // 1 = pressed after normalisation
   assign w_lvl = sync_q[1] ^ c_REL_LVL;

   always_comb begin
      db_d   = db_q;
      stab_d = '0;
      if (w_lvl != db_q) begin
         if (stab_q == c_DB_LAST) begin
            db_d = w_lvl;
         end else begin
            stab_d = stab_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {2{c_REL_LVL}};
         db_q   <= 1'b0;
         stab_q <= '0;
      end else begin
         sync_q <= {sync_q[0], btn_raw_i};
         db_q   <= db_d;
         stab_q <= stab_d;
      end
   end

   assign btn_db_o   = db_q;
   assign btn_pend_o = (w_lvl != db_q);

endmodule
`default_nettype wire

// File: rtl/btn_press_classifier.sv
`default_nettype none
// ==========================================================================
// btn_press_classifier : debounced push-button with short/long press pulses
// Optional auto-repeat of B_L while held: define BTN_AUTO_REPEAT_EN
// Rev 1.0
// ==========================================================================
module btn_press_classifier
   import btn_pkg::*;
#(
   parameter int BTN_ACTIVE_LOW = 1,
   parameter int DEBOUNCE_CYC   = DEBOUNCE_CYC_DEF,
   parameter int LONG_CYC       = LONG_CYC_DEF,
   parameter int REPEAT_CYC     = REPEAT_CYC_DEF,
   parameter int CNT_W          = CNT_W_DEF
) (
   input  logic clk_50MHz,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_db,
   output logic B_S,
   output logic B_L
);

   if ((DEBOUNCE_CYC < 1) || (LONG_CYC < 2) || (REPEAT_CYC < 1) || (CNT_W < 2)) begin : g_cfg_err
      $error("btn_press_classifier: invalid timing parameters");
   end

   // Lockout also covers the two sync stages, which may still hold the pre-reset level
   localparam logic [CNT_W-1:0] c_LOCK_LAST = CNT_W'(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYC - 1);

   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] w_hold_inc;
   logic             bs_q, bs_d;
   logic             bl_q, bl_d;
   logic             w_pend;

`ifdef BTN_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] c_REP_LAST = CNT_W'(REPEAT_CYC - 1);
   logic [CNT_W-1:0] rep_q, rep_d;
`endif

   btn_sync_debounce #(
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW),
      .DEBOUNCE_CYC   (DEBOUNCE_CYC),
      .CNT_W          (CNT_W)
   ) u_sync_debounce (
      .clk_50MHz  (clk_50MHz),
      .rst_n      (rst_n),
      .btn_raw_i  (btn_raw),
      .btn_db_o   (btn_db),
      .btn_pend_o (w_pend)
   );

   assign w_hold_inc = hold_q + 1'b1;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      bs_d    = 1'b0;
      bl_d    = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rep_d   = rep_q;
`endif
      case (state_q)
         LOCKOUT: begin
            if (btn_db || w_pend) begin
               hold_d = '0;
            end else if (hold_q == c_LOCK_LAST) begin
               hold_d  = '0;
               state_d = IDLE;
            end else begin
               hold_d = w_hold_inc;
            end
         end
         IDLE: begin
            hold_d = '0;
            if (btn_db) begin
               state_d = HELD;
            end
         end
         HELD: begin
            // threshold checked first so it wins over a coincident release
            if (btn_db && (w_hold_inc == c_LONG_LAST)) begin
               hold_d  = w_hold_inc;
               bl_d    = 1'b1;
               state_d = LONG;
`ifdef BTN_AUTO_REPEAT_EN
               rep_d   = '0;
`endif
            end else if (!btn_db) begin
               bs_d    = 1'b1;
               state_d = IDLE;
            end else begin
               hold_d = w_hold_inc;
            end
         end
         LONG: begin
            if (!btn_db) begin
               state_d = IDLE;
            end
`ifdef BTN_AUTO_REPEAT_EN
            else if (rep_q == c_REP_LAST) begin
               bl_d  = 1'b1;
               rep_d = '0;
            end else begin
               rep_d = rep_q + 1'b1;
            end
`endif
         end
         default: state_d = LOCKOUT;
      endcase
   end

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOCKOUT;
         hold_q  <= '0;
         bs_q    <= 1'b0;
         bl_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         bs_q    <= bs_d;
         bl_q    <= bl_d;
      end
   end

`ifdef BTN_AUTO_REPEAT_EN
   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         rep_q <= '0;
      end else begin
         rep_q <= rep_d;
      end
   end
`endif

   assign B_S = bs_q;
   assign B_L = bl_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_press_classifier.sv
`default_nettype none
// ==========================================================================
// tb_btn_press_classifier : directed stimulus, press-length model, checks
// Rev 1.0
// ==========================================================================
module tb_btn_press_classifier;

   localparam int DB = 4;
   localparam int LC = 20;
   localparam int RC = 8;
`ifdef BTN_AUTO_REPEAT_EN
   localparam int c_LONG_RAW = 59;
   localparam int c_LONG_NBL = 5;
`else
   localparam int c_LONG_RAW = 60;
   localparam int c_LONG_NBL = 1;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic btn_raw;
   logic btn_db, B_S, B_L;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // scenario observations
   int  n_bs, n_bl, n_rise;
   int  t_press, t_rise, t_dbfall, t_bs, t_bl;
   logic prev_db = 1'b0;

   // model state
   bit m_s1, m_s2, m_db, m_bs, m_bl, m_valid, m_armed;
   int m_hi_len, m_quiet;
   bit m_hist[$];

   btn_press_classifier #(
      .BTN_ACTIVE_LOW (1),
      .DEBOUNCE_CYC   (DB),
      .LONG_CYC       (LC),
      .REPEAT_CYC     (RC),
      .CNT_W          (8)
   ) u_dut (
      .clk_50MHz (clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_raw),
      .btn_db    (btn_db),
      .B_S       (B_S),
      .B_L       (B_L)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // A press of h debounced cycles earns B_L once it has lasted LC cycles
   function automatic bit long_pulse_due(input int h);
      if (h < LC) return 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      return ((h - LC) % RC) == 0;
`else
      return h == LC;
`endif
   endfunction

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_db = 0; m_bs = 0; m_bl = 0;
      m_valid = 0; m_armed = 0; m_hi_len = 0; m_quiet = 0;
      m_hist.delete();
   endtask

   task automatic model_step();
      bit s, db_pre, flip;
      s      = m_s2;
      db_pre = m_db;
      m_bs   = 0;
      m_bl   = 0;
      if (db_pre) begin
         m_hi_len++;
         if (m_hi_len == 1) m_valid = m_armed;
         if (m_valid && long_pulse_due(m_hi_len)) m_bl = 1;
      end else begin
         if (m_valid && (m_hi_len > 0) && (m_hi_len < LC)) m_bs = 1;
         m_hi_len = 0;
         m_valid  = 0;
      end
      if (!db_pre && !s) m_quiet++; else m_quiet = 0;
      if (m_quiet >= DB + 2) m_armed = 1;
      m_hist.push_back(s);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      flip = (m_hist.size() == DB);
      foreach (m_hist[i]) if (m_hist[i] == db_pre) flip = 0;
      if (flip) m_db = !db_pre;
      m_s2 = m_s1;
      m_s1 = !btn_raw;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // per-cycle comparison against the model plus event bookkeeping
   initial forever begin
      @(negedge clk);
      chk_bit("db_model", btn_db, m_db);
      chk_bit("bs_model", B_S, m_bs);
      chk_bit("bl_model", B_L, m_bl);
      chk_bit("bs_bl_excl", B_S & B_L, 1'b0);
      if (btn_db === 1'b1 && prev_db === 1'b0) begin n_rise++; t_rise = cyc; end
      if (btn_db === 1'b0 && prev_db === 1'b1) t_dbfall = cyc;
      if (B_S === 1'b1) begin n_bs++; t_bs = cyc; end
      if (B_L === 1'b1) begin n_bl++; if (n_bl == 1) t_bl = cyc; end
      prev_db = btn_db;
   end

   task automatic clr();
      n_bs = 0; n_bl = 0; n_rise = 0;
      t_rise = -1; t_dbfall = -1; t_bs = -1; t_bl = -1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic hold_low(input int n);
      @(negedge clk);
      btn_raw = 1'b0;
      t_press = cyc;
      repeat (n) @(negedge clk);
      btn_raw = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      btn_raw = 1'b1;
      clr();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_bit("rst_db", btn_db, 1'b0);
      chk_bit("rst_bs", B_S, 1'b0);
      chk_bit("rst_bl", B_L, 1'b0);
      idle(20);

      clr(); hold_low(3); idle(30);
      chk("glitch_rise", n_rise, 0);
      chk("glitch_bs", n_bs, 0);
      chk("glitch_bl", n_bl, 0);

      clr(); hold_low(12); idle(40);
      chk("short_rise_lat", t_rise - t_press, 6);
      chk("short_bs", n_bs, 1);
      chk("short_bl", n_bl, 0);
      chk("short_bs_lat", t_bs - t_dbfall, 1);

      clr(); hold_low(c_LONG_RAW); idle(40);
      chk("long_bl", n_bl, c_LONG_NBL);
      chk("long_bs", n_bs, 0);
      chk("long_bl_lat", t_bl - t_rise, LC);

      clr(); hold_low(LC - 1); idle(40);
      chk("bnd19_len", t_dbfall - t_rise, LC - 1);
      chk("bnd19_bs", n_bs, 1);
      chk("bnd19_bl", n_bl, 0);

      clr(); hold_low(LC); idle(40);
      chk("bnd20_len", t_dbfall - t_rise, LC);
      chk("bnd20_bs", n_bs, 0);
      chk("bnd20_bl", n_bl, 1);

      // reset while the button is held, then keep holding past the long threshold
      clr();
      @(negedge clk);
      btn_raw = 1'b0;
      idle(15);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_bit("midrst_db", btn_db, 1'b0);
      chk_bit("midrst_bs", B_S, 1'b0);
      chk_bit("midrst_bl", B_L, 1'b0);
      idle(3);
      @(negedge clk);
      rst_n = 1'b1;
      idle(30);
      btn_raw = 1'b1;
      idle(40);
      chk("midrst_no_bs", n_bs, 0);
      chk("midrst_no_bl", n_bl, 0);

      clr(); hold_low(12); idle(40);
      chk("after_rst_bs", n_bs, 1);
      chk("after_rst_bl", n_bl, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
